// File: rtl/alu_result_fifo.sv
// First-word-fall-through FIFO that buffers ALU {flag, result} pairs for a downstream consumer.
// It also tracks dropped writes in a sticky overflow bit and counts accepted writes that carry flags.
module alu_result_fifo #(
    parameter int DEPTH  = 8,
    parameter int DATA_W = 8,
    parameter int FLAG_W = 9
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     wr_en,
    input  logic [DATA_W-1:0]        out,
    input  logic [FLAG_W-1:0]        flag,
    input  logic                     rd_ready,
    input  logic                     clr_ovf,
    output logic                     rd_valid,
    output logic [DATA_W-1:0]        rd_data,
    output logic [FLAG_W-1:0]        rd_flag,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     overflow,
    output logic [15:0]              flag_evt_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int EW = DATA_W + FLAG_W;

    logic [EW-1:0] mem_q [DEPTH];

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          ovf_q, ovf_d;
    logic [15:0]   evt_q, evt_d;

    logic          empty_s;
    logic          full_s;
    logic          pop_s;
    logic          push_s;
    logic          drop_s;
    logic [EW-1:0] head_s;

    assign empty_s = (count_q == '0);
    assign full_s  = (count_q == CW'(DEPTH));
    assign pop_s   = !empty_s && rd_ready;
    // A full FIFO still takes a write when the head leaves on the same edge.
    assign push_s  = wr_en && (!full_s || pop_s);
    assign drop_s  = wr_en && !push_s;
    assign head_s  = mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        evt_d    = evt_q;

        if (push_s) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end

        case ({push_s, pop_s})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        // A drop on the clearing edge wins so that the loss is never hidden.
        if (drop_s) begin
            ovf_d = 1'b1;
        end else if (clr_ovf) begin
            ovf_d = 1'b0;
        end

        if (push_s && (flag != '0) && (evt_q != 16'hFFFF)) begin
            evt_d = evt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            evt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            evt_q    <= evt_d;
        end
    end

    // Storage is left uncleared; count gates visibility of stale entries.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_q[wr_ptr_q] <= {flag, out};
        end
    end

    assign rd_valid     = !empty_s;
    assign rd_data      = empty_s ? '0 : head_s[DATA_W-1:0];
    assign rd_flag      = empty_s ? '0 : head_s[EW-1:DATA_W];
    assign count        = count_q;
    assign full         = full_s;
    assign overflow     = ovf_q;
    assign flag_evt_cnt = evt_q;

endmodule

// File: doc/alu_result_fifo.md
ALU_RESULT_FIFO -- requirements
Module: alu_result_fifo

Interface
REQ-001 SHALL have parameter DEPTH, default 8, number of stored entries; it must be a power of two and at least 2.
REQ-002 SHALL have parameter DATA_W, default 8, ALU result width.
REQ-003 SHALL have parameter FLAG_W, default 9, ALU flag-vector width.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port wr_en  input  1  capture the current ALU out/flag this cycle.
REQ-007 SHALL have port out  input  DATA_W  ALU result from the upstream ALU stage.
REQ-008 SHALL have port flag  input  FLAG_W  ALU flag vector from the upstream ALU stage.
REQ-009 SHALL have port rd_ready  input  1  consumer accepts the head entry.
REQ-010 SHALL have port clr_ovf  input  1  synchronous clear of the overflow sticky bit.
REQ-011 SHALL have port rd_valid  output  1  head entry is present.
REQ-012 SHALL have port rd_data  output  DATA_W  result of the head entry.
REQ-013 SHALL have port rd_flag  output  FLAG_W  flags of the head entry.
REQ-014 SHALL have port count  output  clog2(DEPTH)+1  number of stored entries.
REQ-015 SHALL have port full  output  1  high when count equals DEPTH.
REQ-016 SHALL have port overflow  output  1  sticky flag: a write was dropped.
REQ-017 SHALL have port flag_evt_cnt  output  16  number of accepted writes whose flag is nonzero.

Function
REQ-018 SHALL accept a push on a clk edge when wr_en=1 and (full=0 or a pop occurs on the same edge); the pair {flag,out} is stored at wr_ptr, and wr_ptr increments modulo DEPTH.
REQ-019 SHALL perform a pop on a clk edge when rd_valid=1 and rd_ready=1; rd_ptr then increments modulo DEPTH.
REQ-020 SHALL be first-word-fall-through: rd_valid = (count!=0), and rd_data/rd_flag combinationally show the entry at rd_ptr.
REQ-021 SHALL drive rd_data=0 and rd_flag=0 whenever rd_valid=0.
REQ-022 SHALL raise rd_valid in the cycle after the first push into an empty FIFO; there is no same-cycle bypass, so latency is 1 cycle.
REQ-023 SHALL leave count unchanged on a simultaneous push and pop; a push alone adds 1 and a pop alone subtracts 1.
REQ-024 SHALL, when full and a push coincides with a pop, accept both; count stays at DEPTH and overflow is not set.
REQ-025 SHALL, when full with wr_en=1 and no pop, drop the data, leave all pointers unchanged, and set overflow on that edge.
REQ-026 SHALL, when empty with wr_en=1 and rd_ready=1, perform the push only and no pop.
REQ-027 SHALL hold overflow at 1 until clr_ovf=1 at an edge or reset; if clr_ovf and a new drop occur on the same edge, overflow is set.
REQ-028 SHALL increment flag_evt_cnt on each accepted push with flag!=0, saturating at 16'hFFFF.
REQ-029 SHALL ignore rd_ready while empty; pointers and count do not change.

Reset
REQ-030 SHALL, while reset=1 and regardless of clk, force wr_ptr=0, rd_ptr=0, count=0, full=0, rd_valid=0, rd_data=0, rd_flag=0, overflow=0, flag_evt_cnt=0.
REQ-031 SHALL discard all stored contents on reset, including reset asserted mid-operation with entries pending; memory contents need not be cleared.
REQ-032 SHALL resume normal operation on the first rising edge after reset deasserts.

Verification
REQ-033 Single push and pop: push out=8'h7f, flag=9'h000 -> next cycle rd_valid=1, rd_data=8'h7f, count=1, flag_evt_cnt=0; then rd_ready=1 for one edge -> count=0, rd_data=0.
REQ-034 Fill and overflow: 9 consecutive pushes of 8'h00..8'h08 with rd_ready=0 -> full=1, count=8, overflow=1; draining returns 8'h00..8'h07 in order; 8'h08 is lost.
REQ-035 Full with simultaneous push and pop: with the FIFO full, push 8'hAA while rd_ready=1 -> count stays 8, overflow stays 0, 8'hAA becomes the last entry read.
REQ-036 Flag counting: push flag=9'h001, then 9'h000, then 9'h100 -> flag_evt_cnt=2; clr_ovf has no effect on the counter.
REQ-037 Wrap-around: push 12 and pop 12 interleaved, 1 of each per cycle -> data order preserved across the pointer wrap and count never exceeds 1.
REQ-038 Asynchronous reset mid-operation: with count=5 and overflow=1, assert reset between clk edges -> all outputs read 0 immediately, without waiting for an edge.
